alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter FAIR, default 1, SHALL select arbitration: 1 = round-robin, 0 = fixed priority (port 0 wins).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 reqN_valid  input  1  (N=0,1) requester N presents an operation.
REQ-005 reqN_ready  output  1  arbiter accepts requester N's operation this cycle.
REQ-006 reqN_sel  input  4  ALU operation code (add 0000, sub 0001, and 0010, or 0011, xor 0100, sll 0101, srl 0110, sra 0111, slt 1001, sltu 1010).
REQ-007 reqN_a, reqN_b  input  32  operands A and B.
REQ-008 rspN_valid  output  1  result for requester N available.
REQ-009 rspN_ready  input  1  requester N consumes the result.
REQ-010 rspN_data  output  32  result value.
REQ-011 alu_sel  output  4  operation code driven to the shared ALU.
REQ-012 alu_a, alu_b  output  32  operands driven to the shared ALU.
REQ-013 alu_out  input  32  combinational result from the shared ALU.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, EXEC, RESP.
REQ-015 IDLE: if no reqN_valid, remain IDLE; otherwise grant exactly one requester and go to EXEC next cycle.
REQ-016 Arbitration, FAIR=1: one valid -> that one; both valid -> the requester not granted last.
REQ-017 Arbitration, FAIR=0: req0 wins whenever req0_valid=1.
REQ-018 reqN_ready SHALL be combinational, asserted only in IDLE, only for the granted N; never both high.
REQ-019 On acceptance (valid&&ready) the block SHALL register reqN_sel/a/b into alu_sel/alu_a/alu_b and record owner N.
REQ-020 alu_sel/alu_a/alu_b SHALL be driven only from those registers and SHALL stay stable from EXEC until the next acceptance.
REQ-021 EXEC: alu_out SHALL be captured into a 32-bit result register; go to RESP next cycle.
REQ-022 RESP: rspN_valid=1 for the owner only; rspN_data = result register for both N (stable while in RESP).
REQ-023 RESP with owner's rspN_ready=1: return to IDLE next cycle and update the last-granted pointer to owner; otherwise hold RESP with data unchanged.
REQ-024 Latency: acceptance in cycle T SHALL yield rspN_valid first in cycle T+2; minimum issue interval 3 cycles.
REQ-025 Operation codes SHALL be passed through unchanged, including unlisted codes (ALU returns 0); no decoding or checking.
REQ-026 rspN_ready of the non-owner, or in IDLE/EXEC, SHALL be ignored.
REQ-027 reqN_valid deasserted without acceptance SHALL leave no state change; requests arriving during EXEC/RESP wait (ready=0).

Reset
REQ-028 rst_n low SHALL immediately force: state IDLE, alu_sel=0, alu_a=0, alu_b=0, result=0, owner=0, last-granted=1 (req0 wins first contention), rsp0_valid=rsp1_valid=0, req0_ready=req1_ready=0 until rst_n high.
REQ-029 Reset during EXEC or RESP SHALL discard the transaction; no response is ever issued for it.

Verification
REQ-030 Single op: req0 sel=0000 a=5 b=7 accepted cycle T -> rsp0_valid at T+2, rsp0_data=12, rsp1_valid=0.
REQ-031 Contention FAIR=1: both valid continuously after reset, req0 sel=0001 a=10 b=3, req1 sel=0111 a=0x80000000 b=4 -> grants alternate 0,1,0; rsp0_data=7, rsp1_data=0xF8000000.
REQ-032 Fixed priority FAIR=0: both valid continuously -> req1_ready never asserted while req0_valid=1.
REQ-033 Backpressure: req1 sel=1001 a=0xFFFFFFFF b=1, rsp1_ready held low 5 cycles -> rsp1_valid=1, rsp1_data=1 stable all 5 cycles, req0_ready=0 throughout, IDLE one cycle after rsp1_ready=1.
REQ-034 Reset mid-op: assert rst_n low during EXEC -> all outputs 0 asynchronously; after release, no rsp valid until new acceptance; first contention granted to req0.
REQ-035 Unlisted code: sel=1011 a=3 b=4 -> alu_sel=1011 driven, rsp_data=0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Arbitrates two requesters onto one shared, purely combinational ALU.
//   One operation is in flight at a time. The flow is:
//     IDLE -> accept one request -> EXEC (capture alu_out) -> RESP (hold
//     the result until the owner consumes it) -> IDLE.
//
// Parameters
//   FAIR        1 = round-robin between the requesters.
//               0 = fixed priority, where requester 0 always wins.
//
// Ports
//   clk, rst_n                  clock; asynchronous active-low reset
//   reqN_valid/ready            request handshake (N = 0,1).
//                               ready is combinational.
//   reqN_sel/a/b                operation code and operands
//   rspN_valid/ready/data       response handshake and result
//   alu_sel/alu_a/alu_b         registered operation and operands sent to the ALU
//   alu_out                     combinational result returned by the ALU
module alu_arbiter #(
  parameter int unsigned FAIR = 1
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_sel,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_sel,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,

  output logic [3:0]  alu_sel,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic        owner;       // requester that owns the in-flight operation
  logic        last;        // requester most recently served to completion
  logic [31:0] result;

  logic        grant;       // requester that would be accepted this cycle
  logic        accept;
  logic        owner_ready;

  // Grant selection. It is only meaningful while at least one request is valid.
  // When both requesters are valid:
  //   - round-robin favours the one not served last;
  //   - fixed priority always picks requester 0.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      if (FAIR != 0) begin
        grant = ~last;
      end else begin
        grant = 1'b0;
      end
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // Ready is gated with rst_n so both readies read low while reset is held,
  // not only after the first clock.
  assign req0_ready = rst_n && (state == IDLE) && req0_valid && !grant;
  assign req1_ready = rst_n && (state == IDLE) && req1_valid &&  grant;
  assign accept     = req0_ready || req1_ready;

  // Only the owner's rsp_ready matters; the other one is ignored.
  assign owner_ready = owner ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last       <= 1'b1;   // so requester 0 wins the first contention
      result     <= '0;
      alu_sel    <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner   <= grant;
            alu_sel <= grant ? req1_sel : req0_sel;
            alu_a   <= grant ? req1_a   : req0_a;
            alu_b   <= grant ? req1_b   : req0_b;
            state   <= EXEC;
          end
        end
        EXEC: begin
          result     <= alu_out;
          rsp0_valid <= ~owner;
          rsp1_valid <=  owner;
          state      <= RESP;
        end
        RESP: begin
          if (owner_ready) begin
            last       <= owner;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign rsp0_data = result;
  assign rsp1_data = result;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Directed bench with hand-computed expectations.
//   Instance u_fair uses round-robin arbitration (FAIR=1).
//   Instance u_fix uses fixed priority (FAIR=0).
//   Each instance is paired with a behavioural model of the shared ALU.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // ---------------- round-robin DUT signals ----------------
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_sel = '0, req1_sel = '0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] rsp0_data, rsp1_data;
  logic [3:0]  alu_sel;
  logic [31:0] alu_a, alu_b, alu_out;

  // ---------------- fixed-priority DUT signals ----------------
  logic        p_req0_valid = 1'b0, p_req1_valid = 1'b0;
  logic        p_req0_ready, p_req1_ready;
  logic [3:0]  p_req0_sel = '0, p_req1_sel = '0;
  logic [31:0] p_req0_a = '0, p_req0_b = '0, p_req1_a = '0, p_req1_b = '0;
  logic        p_rsp0_valid, p_rsp1_valid;
  logic        p_rsp0_ready = 1'b0, p_rsp1_ready = 1'b0;
  logic [31:0] p_rsp0_data, p_rsp1_data;
  logic [3:0]  p_alu_sel;
  logic [31:0] p_alu_a, p_alu_b, p_alu_out;

  function automatic logic [31:0] alu_model(input logic [3:0] sel,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    case (sel)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return a & b;
      4'b0011: return a | b;
      4'b0100: return a ^ b;
      4'b0101: return a << b[4:0];
      4'b0110: return a >> b[4:0];
      4'b0111: return $unsigned($signed(a) >>> b[4:0]);
      4'b1001: return {31'd0, ($signed(a) < $signed(b))};
      4'b1010: return {31'd0, (a < b)};
      default: return '0;
    endcase
  endfunction

  assign alu_out   = alu_model(alu_sel, alu_a, alu_b);
  assign p_alu_out = alu_model(p_alu_sel, p_alu_a, p_alu_b);

  alu_arbiter #(.FAIR(1)) u_fair (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
    .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out)
  );

  alu_arbiter #(.FAIR(0)) u_fix (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(p_req0_valid), .req0_ready(p_req0_ready), .req0_sel(p_req0_sel),
    .req0_a(p_req0_a), .req0_b(p_req0_b),
    .rsp0_valid(p_rsp0_valid), .rsp0_ready(p_rsp0_ready), .rsp0_data(p_rsp0_data),
    .req1_valid(p_req1_valid), .req1_ready(p_req1_ready), .req1_sel(p_req1_sel),
    .req1_a(p_req1_a), .req1_b(p_req1_b),
    .rsp1_valid(p_rsp1_valid), .rsp1_ready(p_rsp1_ready), .rsp1_data(p_rsp1_data),
    .alu_sel(p_alu_sel), .alu_a(p_alu_a), .alu_b(p_alu_b), .alu_out(p_alu_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    // ---------------- reset state ----------------
    req0_valid = 1'b1;                 // ready must stay low while in reset
    #2;
    check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    check("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    check("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    check("rst_alu_sel", {28'd0, alu_sel}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_rsp_data", rsp0_data, 32'd0);
    req0_valid = 1'b0;
    do_reset();

    // ---------------- single add on req0 ----------------
    req0_sel = 4'b0000; req0_a = 32'd5; req0_b = 32'd7; req0_valid = 1'b1;
    #1;
    check("single_req0_ready", {31'd0, req0_ready}, 32'd1);
    check("single_req1_ready", {31'd0, req1_ready}, 32'd0);
    tick();                            // accepted in cycle T, now in EXEC
    req0_valid = 1'b0;
    req1_valid = 1'b1;                 // arrives during EXEC and must wait
    #1;
    check("exec_req1_wait", {31'd0, req1_ready}, 32'd0);
    check("exec_no_rsp", {31'd0, rsp0_valid}, 32'd0);
    check("exec_alu_a", alu_a, 32'd5);
    check("exec_alu_b", alu_b, 32'd7);
    req1_valid = 1'b0;
    tick();                            // T+2: now in RESP
    check("single_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    check("single_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    check("single_rsp0_data", rsp0_data, 32'd12);
    rsp0_ready = 1'b1;
    tick();
    check("single_back_idle", {31'd0, rsp0_valid}, 32'd0);
    rsp0_ready = 1'b0;

    // ---------------- round-robin contention ----------------
    do_reset();
    req0_sel = 4'b0001; req0_a = 32'd10;         req0_b = 32'd3;
    req1_sel = 4'b0111; req1_a = 32'h8000_0000;  req1_b = 32'd4;
    req0_valid = 1'b1; req1_valid = 1'b1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      logic exp_g;
      exp_g = (i == 1);                // expected grant order 0,1,0
      check($sformatf("rr%0d_ready0", i), {31'd0, req0_ready}, {31'd0, !exp_g});
      check($sformatf("rr%0d_ready1", i), {31'd0, req1_ready}, {31'd0, exp_g});
      tick();                          // EXEC
      tick();                          // RESP
      if (exp_g) begin
        check($sformatf("rr%0d_rsp1_valid", i), {31'd0, rsp1_valid}, 32'd1);
        check($sformatf("rr%0d_data", i), rsp1_data, 32'hF800_0000);
      end else begin
        check($sformatf("rr%0d_rsp0_valid", i), {31'd0, rsp0_valid}, 32'd1);
        check($sformatf("rr%0d_data", i), rsp0_data, 32'd7);
      end
      tick();                          // IDLE
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // ---------------- fixed priority ----------------
    do_reset();
    p_req0_sel = 4'b0010; p_req0_a = 32'hF0F0; p_req0_b = 32'hFF00;
    p_req1_sel = 4'b0011; p_req1_a = 32'h1;    p_req1_b = 32'h2;
    p_req0_valid = 1'b1; p_req1_valid = 1'b1;
    p_rsp0_ready = 1'b1; p_rsp1_ready = 1'b1;
    #1;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("fix%0d_req1_ready", i), {31'd0, p_req1_ready}, 32'd0);
      check($sformatf("fix%0d_rsp1_valid", i), {31'd0, p_rsp1_valid}, 32'd0);
      if (i % 3 == 2) check($sformatf("fix%0d_data", i), p_rsp0_data, 32'h0000_F000);
      tick();
    end
    p_req0_valid = 1'b0;
    #1;
    check("fix_req1_alone", {31'd0, p_req1_ready}, 32'd1);
    p_req1_valid = 1'b0;

    // ---------------- backpressure on req1 (slt) ----------------
    do_reset();
    req1_sel = 4'b1001; req1_a = 32'hFFFF_FFFF; req1_b = 32'd1; req1_valid = 1'b1;
    #1;
    check("bp_req1_ready", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    tick();                            // RESP
    req0_valid = 1'b1; req0_sel = 4'b0000; req0_a = 32'd1; req0_b = 32'd1;
    rsp0_ready = 1'b1;                 // non-owner ready must be ignored
    #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d_rsp1_valid", i), {31'd0, rsp1_valid}, 32'd1);
      check($sformatf("bp%0d_rsp1_data", i), rsp1_data, 32'd1);
      check($sformatf("bp%0d_req0_ready", i), {31'd0, req0_ready}, 32'd0);
      check($sformatf("bp%0d_rsp0_valid", i), {31'd0, rsp0_valid}, 32'd0);
      if (i < 4) tick();
    end
    rsp1_ready = 1'b1;
    tick();
    check("bp_idle_rsp1", {31'd0, rsp1_valid}, 32'd0);
    check("bp_idle_req0_ready", {31'd0, req0_ready}, 32'd1);
    req0_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // ---------------- reset during EXEC ----------------
    do_reset();
    req1_sel = 4'b0000; req1_a = 32'd1; req1_b = 32'd1; req1_valid = 1'b1;
    tick();                            // accepted, now in EXEC
    req1_valid = 1'b0;
    check("mid_alu_a", alu_a, 32'd1);
    #2;
    rst_n = 1'b0;
    req0_valid = 1'b1;
    #1;
    check("mid_alu_sel", {28'd0, alu_sel}, 32'd0);
    check("mid_alu_a0", alu_a, 32'd0);
    check("mid_alu_b0", alu_b, 32'd0);
    check("mid_data", rsp1_data, 32'd0);
    check("mid_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    tick();
    req0_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    rsp1_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mid%0d_no_rsp", i), {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    end
    rsp1_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("mid_first_ready0", {31'd0, req0_ready}, 32'd1);
    check("mid_first_ready1", {31'd0, req1_ready}, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // ---------------- unlisted operation code ----------------
    do_reset();
    req0_sel = 4'b1011; req0_a = 32'd3; req0_b = 32'd4; req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    check("unl_alu_sel", {28'd0, alu_sel}, 32'h0000_000B);
    tick();
    check("unl_rsp_valid", {31'd0, rsp0_valid}, 32'd1);
    check("unl_rsp_data", rsp0_data, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
